rst_seq_synch: RTL and testbench

Parametrised reset synchroniser and sequencer. It takes the raw asynchronous push-button reset and a synchronous software reset request, and produces `NUM_OUT` active-low reset outputs. All outputs assert together and are released one at a time, in a fixed order, after a minimum hold time. It sits at the top level between the board reset pin and the reset inputs of the core, memory and peripheral subsystems, and it also reports the cause of the last reset.

---
 rtl/rst_seq_synch.sv | 115 +++++++++++
 tb/tb_rst_seq_synch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_synch.sv
// Reset synchroniser and sequencer: all outputs assert together, then release one by one.
// A pin reset clears everything asynchronously; a software request re-runs the sequence from RUN.
module rst_seq_synch #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_OUT        = 3,
  parameter int RELEASE_GAP    = 4
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam int GAP_W = $clog2(RELEASE_GAP + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [1:0] CAUSE_PIN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {STRETCH, RELEASE, RUN} state_t;

  state_t             state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] rst_n_q;
  logic               rst_done_q;
  logic [1:0]         cause_q;
  logic               req_prev_q;
  logic               sync_ok;
  logic               sw_trig;

  // Release of the pin is synchronised; assertion bypasses the chain via the async clear.
  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];
  assign sw_trig = sw_rst_req & ~req_prev_q;

  always_comb begin
    cnt_d = (cnt_q == CNT_W'(STRETCH_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    gap_d = (gap_q == GAP_W'(RELEASE_GAP)) ? gap_q : gap_q + 1'b1;
  end

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= STRETCH;
      cnt_q      <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      rst_done_q <= 1'b0;
      cause_q    <= CAUSE_PIN;
      req_prev_q <= 1'b1;
    end else begin
      req_prev_q <= sw_rst_req;
      unique case (state_q)
        STRETCH: begin
          if (sync_ok) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(STRETCH_CYCLES)) begin
              rst_n_q[0] <= 1'b1;
              gap_q      <= '0;
              idx_q      <= IDX_W'(1);
              state_q    <= (NUM_OUT == 1) ? RUN : RELEASE;
            end
          end
        end
        RELEASE: begin
          gap_q <= gap_d;
          if (gap_d == GAP_W'(RELEASE_GAP)) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx_q == IDX_W'(k)) begin
                rst_n_q[k] <= 1'b1;
              end
            end
            gap_q <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_OUT - 1)) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rst_done_q <= 1'b1;
          // Only a fresh 0->1 request restarts the sequence; sync_ok is already high here.
          if (sw_trig) begin
            rst_n_q    <= '0;
            rst_done_q <= 1'b0;
            cause_q    <= CAUSE_SW;
            cnt_q      <= '0;
            state_q    <= STRETCH;
          end
        end
        default: begin
          state_q <= STRETCH;
        end
      endcase
    end
  end

  assign rst_n     = rst_n_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_synch.sv
// Scoreboard bench for rst_seq_synch: default instance plus two parameter-sweep instances.
// Stimulus pushes expected {edge, rst_n, rst_done, rst_cause} entries; monitors pop on every output change.
module tb_rst_seq_synch;

  typedef struct {
    int         edgeIdx;
    logic [6:0] val;
  } expT;

  logic clk = 1'b0;
  logic rstMain = 1'b1;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  logic swMain = 1'b0;
  logic swA = 1'b0;
  logic swB = 1'b0;

  logic [2:0] rnMain;
  logic       doneMain;
  logic [1:0] causeMain;
  logic [0:0] rnA;
  logic       doneA;
  logic [1:0] causeA;
  logic [3:0] rnB;
  logic       doneB;
  logic [1:0] causeB;

  int edgeNo = 0;
  int edgeBase = 0;
  int checks = 0;
  int errors = 0;

  expT qMain[$];
  expT qA[$];
  expT qB[$];

  rst_seq_synch dutMain (
    .clk(clk), .RST_n(rstMain), .sw_rst_req(swMain),
    .rst_n(rnMain), .rst_done(doneMain), .rst_cause(causeMain)
  );

  rst_seq_synch #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUM_OUT(1), .RELEASE_GAP(1)
  ) dutA (
    .clk(clk), .RST_n(rstA), .sw_rst_req(swA),
    .rst_n(rnA), .rst_done(doneA), .rst_cause(causeA)
  );

  rst_seq_synch #(
    .SYNC_STAGES(2), .STRETCH_CYCLES(16), .NUM_OUT(4), .RELEASE_GAP(2)
  ) dutB (
    .clk(clk), .RST_n(rstB), .sw_rst_req(swB),
    .rst_n(rnB), .rst_done(doneB), .rst_cause(causeB)
  );

  always #5 clk = ~clk;

  // Falling edges are numbered relative to the start of the current epoch.
  always @(negedge clk) edgeNo = edgeNo + 1;

  function automatic int relEdge();
    return edgeNo - edgeBase;
  endfunction

  task automatic startEpoch();
    edgeBase = edgeNo;
  endtask

  task automatic waitEdge(input int n);
    int guard;
    guard = 0;
    while (relEdge() < n && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
  endtask

  task automatic applyStimulus(input int which, input logic pin, input logic sw);
    case (which)
      0: begin rstMain = pin; swMain = sw; end
      1: begin rstA = pin; swA = sw; end
      default: begin rstB = pin; swB = sw; end
    endcase
  endtask

  task automatic expectOut(input int which, input int e, input logic [3:0] rn,
                           input logic d, input logic [1:0] c);
    expT x;
    x.edgeIdx = e;
    x.val = {rn, d, c};
    case (which)
      0: qMain.push_back(x);
      1: qA.push_back(x);
      default: qB.push_back(x);
    endcase
  endtask

  // Default-parameter release pattern starting at edge r0.
  task automatic expectMain(input int r0, input logic [1:0] c);
    expectOut(0, r0,     4'b0001, 1'b0, c);
    expectOut(0, r0 + 4, 4'b0011, 1'b0, c);
    expectOut(0, r0 + 8, 4'b0111, 1'b0, c);
    expectOut(0, r0 + 9, 4'b0111, 1'b1, c);
  endtask

  task automatic checkOutput(input int which, input logic [6:0] obs);
    expT e;
    bit have;
    string nm;
    have = 1'b0;
    case (which)
      0: begin nm = "main";   if (qMain.size() > 0) begin e = qMain.pop_front(); have = 1'b1; end end
      1: begin nm = "sweepA"; if (qA.size() > 0) begin e = qA.pop_front(); have = 1'b1; end end
      default: begin nm = "sweepB"; if (qB.size() > 0) begin e = qB.pop_front(); have = 1'b1; end end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("[TB] FAIL %s unexpected_change: got {rst_n,done,cause}=%b at edge %0d, required no change",
               nm, obs, relEdge());
    end else begin
      if (obs !== e.val) begin
        errors++;
        $display("[TB] FAIL %s value: got {rst_n,done,cause}=%b, required %b (edge %0d)",
                 nm, obs, e.val, e.edgeIdx);
      end
      checks++;
      if (relEdge() != e.edgeIdx) begin
        errors++;
        $display("[TB] FAIL %s timing: change to %b seen at edge %0d, required edge %0d",
                 nm, obs, relEdge(), e.edgeIdx);
      end
    end
  endtask

  // Monitors sample 1 time unit after a rising clock edge or a pin reset assertion.
  initial begin : monMain
    logic [6:0] last, now;
    last = 'x;
    forever begin
      @(posedge clk or negedge rstMain);
      #1;
      now = {1'b0, rnMain, doneMain, causeMain};
      if (now !== last) begin
        checkOutput(0, now);
        last = now;
      end
    end
  end

  initial begin : monA
    logic [6:0] last, now;
    last = 'x;
    forever begin
      @(posedge clk or negedge rstA);
      #1;
      now = {3'b000, rnA, doneA, causeA};
      if (now !== last) begin
        checkOutput(1, now);
        last = now;
      end
    end
  end

  initial begin : monB
    logic [6:0] last, now;
    last = 'x;
    forever begin
      @(posedge clk or negedge rstB);
      #1;
      now = {rnB, doneB, causeB};
      if (now !== last) begin
        checkOutput(2, now);
        last = now;
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required stimulus to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    #1;
    expectOut(0, 0, 4'b0000, 1'b0, 2'b01);
    expectOut(1, 0, 4'b0000, 1'b0, 2'b01);
    expectOut(2, 0, 4'b0000, 1'b0, 2'b01);
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0);

    // Pin release with the software request held high throughout: no software reset.
    repeat (3) @(posedge clk);
    startEpoch();
    expectMain(18, 2'b01);
    applyStimulus(0, 1'b1, 1'b1);
    waitEdge(30);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(33);

    // Software reset from RUN, trigger sampled at edge 1.
    startEpoch();
    expectOut(0, 1, 4'b0000, 1'b0, 2'b10);
    expectMain(17, 2'b10);
    applyStimulus(0, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(30);

    // Second software reset; extra pulses in STRETCH and RELEASE must not move releases.
    startEpoch();
    expectOut(0, 1, 4'b0000, 1'b0, 2'b10);
    expectMain(17, 2'b10);
    applyStimulus(0, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(8);
    applyStimulus(0, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(19);
    applyStimulus(0, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(30);

    // Pin reset from RUN, then a second pin reset in the middle of RELEASE.
    expectOut(0, relEdge(), 4'b0000, 1'b0, 2'b01);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    startEpoch();
    expectOut(0, 18, 4'b0001, 1'b0, 2'b01);
    expectOut(0, 22, 4'b0011, 1'b0, 2'b01);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(24);
    expectOut(0, 24, 4'b0000, 1'b0, 2'b01);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    startEpoch();
    expectMain(18, 2'b01);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(30);

    // Pin reset falls on the same edge that samples a software trigger.
    startEpoch();
    expectOut(0, 1, 4'b0000, 1'b0, 2'b01);
    applyStimulus(0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1);
    @(posedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    startEpoch();
    expectMain(18, 2'b01);
    applyStimulus(0, 1'b1, 1'b0);
    waitEdge(30);

    // Minimal configuration: 3 sync stages, 1 stretch cycle, single output.
    startEpoch();
    expectOut(1, 4, 4'b0001, 1'b0, 2'b01);
    expectOut(1, 5, 4'b0001, 1'b1, 2'b01);
    applyStimulus(1, 1'b1, 1'b0);
    waitEdge(8);
    startEpoch();
    expectOut(1, 1, 4'b0000, 1'b0, 2'b10);
    expectOut(1, 2, 4'b0001, 1'b0, 2'b10);
    expectOut(1, 3, 4'b0001, 1'b1, 2'b10);
    applyStimulus(1, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(1, 1'b1, 1'b0);
    waitEdge(6);

    // Four outputs released two edges apart.
    startEpoch();
    expectOut(2, 18, 4'b0001, 1'b0, 2'b01);
    expectOut(2, 20, 4'b0011, 1'b0, 2'b01);
    expectOut(2, 22, 4'b0111, 1'b0, 2'b01);
    expectOut(2, 24, 4'b1111, 1'b0, 2'b01);
    expectOut(2, 25, 4'b1111, 1'b1, 2'b01);
    applyStimulus(2, 1'b1, 1'b0);
    waitEdge(30);
    repeat (3) @(posedge clk);

    checks++;
    if (qMain.size() != 0) begin
      errors++;
      $display("[TB] FAIL main pending: %0d expected changes never seen, next at edge %0d, required 0 pending",
               qMain.size(), qMain[0].edgeIdx);
    end
    checks++;
    if (qA.size() != 0) begin
      errors++;
      $display("[TB] FAIL sweepA pending: %0d expected changes never seen, next at edge %0d, required 0 pending",
               qA.size(), qA[0].edgeIdx);
    end
    checks++;
    if (qB.size() != 0) begin
      errors++;
      $display("[TB] FAIL sweepB pending: %0d expected changes never seen, next at edge %0d, required 0 pending",
               qB.size(), qB[0].edgeIdx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
